sa48_chunk_sender: RTL and testbench

//   Transmit side of the SA48 chunked-operand interface. Accepts two 48-bit

---
 rtl/sa48_chunk_sender_if.sv | 31 +++
 rtl/sa48_chunk_sender.sv | 150 +++++++++++++++
 tb/tb_sa48_chunk_sender.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/sa48_chunk_sender_if.sv
// Operand and chunk-bus signals between the SA48 chunk sender and its environment.
// master = the sender itself; slave = operand source / chunk consumer side.
interface sa48_chunk_sender_if #(
    parameter int CHUNK_W    = 12,
    parameter int NUM_CHUNKS = 4
);
    localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    logic                          in_valid;
    logic                          in_ready;
    logic [CHUNK_W*NUM_CHUNKS-1:0] op_a;
    logic [CHUNK_W*NUM_CHUNKS-1:0] op_b;
    logic                          start_chunks;
    logic [CHUNK_W-1:0]            bus_a;
    logic [CHUNK_W-1:0]            bus_b;
    logic                          chunk_valid;
    logic [IDX_W-1:0]              chunk_idx;
    logic                          result_ready;
    logic                          done;
    logic                          err;

    modport master (
        input  in_valid, op_a, op_b, result_ready,
        output in_ready, start_chunks, bus_a, bus_b, chunk_valid, chunk_idx, done, err
    );

    modport slave (
        output in_valid, op_a, op_b, result_ready,
        input  in_ready, start_chunks, bus_a, bus_b, chunk_valid, chunk_idx, done, err
    );
endinterface

// File: rtl/sa48_chunk_sender.sv
// SA48 chunk sender: latches an operand pair, emits a start pulse, streams the
// operands LS chunk first, then waits (bounded) for the consumer's result_ready.
module sa48_chunk_sender #(
    parameter int CHUNK_W    = 12,
    parameter int NUM_CHUNKS = 4,
    parameter int TIMEOUT    = 16
) (
    input logic                 clk,
    input logic                 rst,
    sa48_chunk_sender_if.master ifc
);
    localparam int OP_W  = CHUNK_W * NUM_CHUNKS;
    localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_CHUNKS - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        START    = 2'd1,
        SEND     = 2'd2,
        WAIT_RES = 2'd3
    } state_t;

    state_t             state_r, stateNext_s;
    logic [OP_W-1:0]    opA_r, opANext_s, opB_r, opBNext_s;
    logic [CNT_W-1:0]   cnt_r, cntNext_s, cntPlus_s;
    logic               inReady_r, inReadyNext_s;
    logic               startChunks_r, startChunksNext_s;
    logic [CHUNK_W-1:0] busA_r, busANext_s, busB_r, busBNext_s;
    logic               chunkValid_r, chunkValidNext_s;
    logic [IDX_W-1:0]   chunkIdx_r, chunkIdxNext_s;
    logic               done_r, doneNext_s;
    logic               err_r, errNext_s;

    // The counter holds at TIMEOUT instead of wrapping.
    assign cntPlus_s = (cnt_r == TIMEOUT_CNT) ? cnt_r : cnt_r + CNT_W'(1);

    // Next-state and next-output logic; outputs are registered one cycle ahead.
    always_comb begin
        stateNext_s       = state_r;
        opANext_s         = opA_r;
        opBNext_s         = opB_r;
        cntNext_s         = cnt_r;
        inReadyNext_s     = 1'b0;
        startChunksNext_s = 1'b0;
        busANext_s        = {CHUNK_W{1'b0}};
        busBNext_s        = {CHUNK_W{1'b0}};
        chunkValidNext_s  = 1'b0;
        chunkIdxNext_s    = {IDX_W{1'b0}};
        doneNext_s        = 1'b0;
        errNext_s         = 1'b0;
        case (state_r)
            IDLE: begin
                // in_ready is low during the done/err cycle, so that cycle never accepts.
                inReadyNext_s = 1'b1;
                if (ifc.in_valid && inReady_r) begin
                    stateNext_s       = START;
                    opANext_s         = ifc.op_a;
                    opBNext_s         = ifc.op_b;
                    cntNext_s         = {CNT_W{1'b0}};
                    inReadyNext_s     = 1'b0;
                    startChunksNext_s = 1'b1;
                end else begin
                    stateNext_s = IDLE;
                end
            end
            START: begin
                stateNext_s      = SEND;
                chunkValidNext_s = 1'b1;
                chunkIdxNext_s   = {IDX_W{1'b0}};
                busANext_s       = opA_r[CHUNK_W-1:0];
                busBNext_s       = opB_r[CHUNK_W-1:0];
                opANext_s        = opA_r >> CHUNK_W;
                opBNext_s        = opB_r >> CHUNK_W;
            end
            SEND: begin
                if (chunkIdx_r == LAST_IDX) begin
                    stateNext_s = WAIT_RES;
                    cntNext_s   = {CNT_W{1'b0}};
                end else begin
                    chunkValidNext_s = 1'b1;
                    chunkIdxNext_s   = chunkIdx_r + IDX_W'(1);
                    busANext_s       = opA_r[CHUNK_W-1:0];
                    busBNext_s       = opB_r[CHUNK_W-1:0];
                    opANext_s        = opA_r >> CHUNK_W;
                    opBNext_s        = opB_r >> CHUNK_W;
                end
            end
            WAIT_RES: begin
                // result_ready takes priority over a timeout in the same cycle.
                if (ifc.result_ready) begin
                    stateNext_s = IDLE;
                    doneNext_s  = 1'b1;
                    cntNext_s   = {CNT_W{1'b0}};
                end else if (cntPlus_s == TIMEOUT_CNT) begin
                    stateNext_s = IDLE;
                    errNext_s   = 1'b1;
                    cntNext_s   = {CNT_W{1'b0}};
                end else begin
                    cntNext_s = cntPlus_s;
                end
            end
            default: begin
                stateNext_s   = IDLE;
                inReadyNext_s = 1'b1;
            end
        endcase
    end

    // State, operand shift registers, timeout counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            opA_r         <= {OP_W{1'b0}};
            opB_r         <= {OP_W{1'b0}};
            cnt_r         <= {CNT_W{1'b0}};
            inReady_r     <= 1'b1;
            startChunks_r <= 1'b0;
            busA_r        <= {CHUNK_W{1'b0}};
            busB_r        <= {CHUNK_W{1'b0}};
            chunkValid_r  <= 1'b0;
            chunkIdx_r    <= {IDX_W{1'b0}};
            done_r        <= 1'b0;
            err_r         <= 1'b0;
        end else begin
            state_r       <= stateNext_s;
            opA_r         <= opANext_s;
            opB_r         <= opBNext_s;
            cnt_r         <= cntNext_s;
            inReady_r     <= inReadyNext_s;
            startChunks_r <= startChunksNext_s;
            busA_r        <= busANext_s;
            busB_r        <= busBNext_s;
            chunkValid_r  <= chunkValidNext_s;
            chunkIdx_r    <= chunkIdxNext_s;
            done_r        <= doneNext_s;
            err_r         <= errNext_s;
        end
    end

    assign ifc.in_ready     = inReady_r;
    assign ifc.start_chunks = startChunks_r;
    assign ifc.bus_a        = busA_r;
    assign ifc.bus_b        = busB_r;
    assign ifc.chunk_valid  = chunkValid_r;
    assign ifc.chunk_idx    = chunkIdx_r;
    assign ifc.done         = done_r;
    assign ifc.err          = err_r;
endmodule

// File: tb/tb_sa48_chunk_sender.sv
// Bench for sa48_chunk_sender: directed and randomized transfers checked cycle
// by cycle against a per-transfer timeline model.
module tb_sa48_chunk_sender;
    localparam int CW = 12;
    localparam int NC = 4;
    localparam int TO = 16;
    localparam logic [30:0] IDLE_V = {1'b1, 30'b0};

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    sa48_chunk_sender_if #(.CHUNK_W(CW), .NUM_CHUNKS(NC)) ifc ();

    sa48_chunk_sender #(.CHUNK_W(CW), .NUM_CHUNKS(NC), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .ifc (ifc)
    );

    // Expected outputs n cycles after the accepting edge; w = wait cycle index
    // at which the outcome is decided, isErr selects err over done.
    function automatic logic [30:0] model(int n, logic [47:0] a, logic [47:0] b, int w, bit isErr);
        logic ir = 1'b0, st = 1'b0, cv = 1'b0, dn = 1'b0, er = 1'b0;
        logic [1:0]  ix = 2'd0;
        logic [11:0] ba = 12'd0, bb = 12'd0;
        logic [47:0] sa, sb;
        if (n == 1) begin
            st = 1'b1;
        end else if (n >= 2 && n <= NC + 1) begin
            cv = 1'b1;
            ix = 2'(n - 2);
            sa = a >> (CW * (n - 2));
            sb = b >> (CW * (n - 2));
            ba = sa[11:0];
            bb = sb[11:0];
        end else if (n == NC + 3 + w) begin
            dn = !isErr;
            er = isErr;
        end else if (n >= NC + 4 + w) begin
            ir = 1'b1;
        end
        return {ir, st, cv, ix, ba, bb, dn, er};
    endfunction

    function automatic logic [30:0] obsv();
        return {ifc.in_ready, ifc.start_chunks, ifc.chunk_valid, ifc.chunk_idx,
                ifc.bus_a, ifc.bus_b, ifc.done, ifc.err};
    endfunction

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [30:0] o, input logic [30:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            ifc.in_valid     = 1'b0;
            ifc.result_ready = 1'($urandom_range(0, 1));
            nextCycle();
            check($sformatf("idle%0d", i), obsv(), IDLE_V);
        end
    endtask

    // One complete transfer starting in an idle cycle; returns in the idle cycle after done/err.
    // rrAt = wait cycle index at which result_ready rises (>= TO means never).
    task automatic txn(input string tag, input logic [47:0] a, input logic [47:0] b,
                       input int rrAt, input bit held);
        int w;
        bit isErr;
        isErr = (rrAt >= TO);
        w     = isErr ? TO - 1 : rrAt;
        check({tag, "/ready"}, obsv(), IDLE_V);
        ifc.in_valid     = 1'b1;
        ifc.op_a         = a;
        ifc.op_b         = b;
        ifc.result_ready = 1'($urandom_range(0, 1));
        for (int n = 1; n <= NC + 4 + w; n++) begin
            nextCycle();
            check($sformatf("%s/n%0d", tag, n), obsv(), model(n, a, b, w, isErr));
            ifc.in_valid = (n < NC + 4 + w) ? 1'($urandom_range(0, 1)) : 1'b0;
            ifc.op_a     = 48'({$urandom(), $urandom()});
            ifc.op_b     = 48'({$urandom(), $urandom()});
            if (n <= NC + 1)
                ifc.result_ready = held | 1'($urandom_range(0, 1));
            else if (n <= NC + 2 + w)
                ifc.result_ready = held || (n - (NC + 2) == rrAt);
            else
                ifc.result_ready = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        logic [47:0] ra, rb;
        rst              = 1'b1;
        ifc.in_valid     = 1'b0;
        ifc.op_a         = 48'd0;
        ifc.op_b         = 48'd0;
        ifc.result_ready = 1'b0;
        nextCycle();
        nextCycle();
        check("reset", obsv(), IDLE_V);
        rst = 1'b0;
        idle(2);

        txn("basic", 48'h123456789ABC, 48'h000FFF000FFF, 0, 1'b0);
        idle(2);
        txn("timeout", 48'hFEDCBA987654, 48'h0123456789AB, TO + 5, 1'b0);
        txn("held", 48'hAAAA5555AAAA, 48'h5555AAAA5555, 0, 1'b1);
        idle(1);
        txn("tie", 48'h000000000001, 48'h800000000000, TO - 1, 1'b0);

        // Reset while chunk 1 is on the buses aborts without done/err.
        ifc.in_valid = 1'b1;
        ifc.op_a     = 48'hCAFEF00DBEEF;
        ifc.op_b     = 48'h0F0F0F0F0F0F;
        for (int n = 1; n <= 3; n++) begin
            nextCycle();
            check($sformatf("abort/n%0d", n), obsv(), model(n, 48'hCAFEF00DBEEF, 48'h0F0F0F0F0F0F, 0, 1'b0));
            ifc.in_valid     = 1'b0;
            ifc.result_ready = 1'($urandom_range(0, 1));
        end
        rst = 1'b1;
        nextCycle();
        check("abort/rst", obsv(), IDLE_V);
        rst = 1'b0;
        idle(20);
        txn("fresh", 48'h0000000ABCDE, 48'h111122223333, 2, 1'b0);

        for (int i = 0; i < 4; i++) begin
            ra = 48'({$urandom(), $urandom()});
            rb = 48'({$urandom(), $urandom()});
            txn($sformatf("b2b%0d", i), ra, rb, 0, 1'b0);
        end

        for (int i = 0; i < 12; i++) begin
            ra = 48'({$urandom(), $urandom()});
            rb = 48'({$urandom(), $urandom()});
            if ($urandom_range(0, 3) == 0)
                txn($sformatf("rnd%0d", i), ra, rb, 0, 1'b1);
            else
                txn($sformatf("rnd%0d", i), ra, rb, int'($urandom_range(0, TO + 2)), 1'b0);
            idle(int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
